rf_1r1w_port_arbiter: RTL and testbench
=======================================

// Module: rf_1r1w_port_arbiter
// PURPOSE
//  - Shares one register_file_1r_1w instance between N_PORTS requesters.
//  - Independent round-robin arbitration on the read port and on the write port.
//  - Routes the registered read data back to the granted requester.
//  - Sits between engine-side access ports and the single-port SCM-equivalent RF.
// PARAMETERS
//  N_PORTS     4   number of requesters (>=2)
//  ADDR_WIDTH  5   RF address width; must equal the RF instance ADDR_WIDTH
//  DATA_WIDTH  64  RF data width; must equal the RF instance DATA_WIDTH
// PORTS
//  clk          in   1                   clock
//  rst_n        in   1                   reset, asynchronous, active-low
//  rd_req_i     in   N_PORTS             per-port read request
//  rd_addr_i    in   N_PORTS*ADDR_WIDTH  per-port read address
//  rd_gnt_o     out  N_PORTS             read grant, one-hot or zero, combinational
//  rd_rvalid_o  out  N_PORTS             read data valid for port i, one-hot or zero
//  rd_rdata_o   out  DATA_WIDTH          read data, shared by all ports
//  wr_req_i     in   N_PORTS             per-port write request
//  wr_addr_i    in   N_PORTS*ADDR_WIDTH  per-port write address
//  wr_data_i    in   N_PORTS*DATA_WIDTH  per-port write data
//  wr_gnt_o     out  N_PORTS             write grant, one-hot or zero, combinational
//  rf_ren_o     out  1                   to RF ReadEnable
//  rf_raddr_o   out  ADDR_WIDTH          to RF ReadAddr
//  rf_rdata_i   in   DATA_WIDTH          from RF ReadData (1-cycle registered)
//  rf_wen_o     out  1                   to RF WriteEnable
//  rf_waddr_o   out  ADDR_WIDTH          to RF WriteAddr
//  rf_wdata_o   out  DATA_WIDTH          to RF WriteData
// BEHAVIOUR
//  - Handshake: a transfer occurs in a cycle with req_i[i] & gnt_o[i].
//    The requester holds req, addr and data stable until granted.
//  - Grant is combinational from req and the priority pointer. It is issued in
//    the request cycle, with zero bubble.
//  - RR pointer: rd_ptr_q and wr_ptr_q mark the highest-priority port.
//    Scan from ptr upward, wrapping modulo N_PORTS.
//    After a grant to port k, ptr <= (k+1) mod N_PORTS.
//    With no grant, ptr holds.
//  - rf_ren_o = |rd_gnt_o; rf_raddr_o = rd_addr_i[granted]; else rf_raddr_o = '0.
//  - rf_wen_o = |wr_gnt_o; rf_waddr_o and rf_wdata_o come from the granted port;
//    else both are '0.
//  - Read latency is 1 cycle. A grant in cycle t gives rd_rvalid_o[k] = 1 in t+1
//    for exactly one cycle. rd_rdata_o = rf_rdata_i in that cycle.
//  - rd_rdata_o is don't-care while no rvalid is asserted. It is driven as
//    rf_rdata_i.
//  - Back-to-back reads are supported every cycle, one per cycle total across
//    all ports.
//  - Read and write channels are fully independent. One read and one write can
//    both complete in the same cycle.
//  - Same-address read and write in the same cycle return the OLD value
//    (read-before-write). The write is visible to reads granted from t+1 on.
//    No forwarding and no stall.
//  - Write to the address read in the previous cycle does not alter the pending
//    rd_rdata_o.
//  - Reset values: rd_ptr_q=0, wr_ptr_q=0, rd_pend_q=0, rd_id_q=0,
//    rd_rvalid_o='0. Grants and rf_* outputs follow the inputs combinationally.
//  - Reset mid-operation discards any pending read: rd_rvalid_o goes low
//    immediately (asynchronous) and no response is generated after release.
//  - N_PORTS not a power of two: pointer wrap is explicit compare-to-N_PORTS-1,
//    never relying on overflow.
// STRUCTURE
//  - Package rf_arb_pkg holds:
//    - port_idx_t = logic [$clog2(N_PORTS)-1:0]
//    - function onehot_to_idx
//    - localparam RF_READ_LATENCY = 1
//  - Sub-module rf_rr_arbiter (req vector -> one-hot gnt + idx, owns the
//    pointer flop), instantiated twice: read and write.
//  - Top level holds the rd_pend_q/rd_id_q response pipeline and the address
//    and data muxes.
// TESTING
//  1. Reset, then all rd_req=4'b1111 held 8 cycles -> grant order is ports
//     0,1,2,3,0,1,2,3. Each rvalid arrives 1 cycle after its grant.
//  2. RF preloaded with mem[3]=0xA5; port 2 reads addr 3 in cycle t ->
//     rd_rvalid_o=4'b0100 and rd_rdata_o=0xA5 in t+1 only.
//  3. Port 1 writes addr 7 = 0x1234 and port 0 reads addr 7 in the same cycle ->
//     old value returned. A read of addr 7 in the next cycle returns 0x1234.
//  4. wr_req=4'b1010 and rd_req=4'b0101 simultaneously -> wr_gnt=0010 and
//     rd_gnt=0001 in the same cycle. Next cycle: wr_gnt=1000, rd_gnt=0100.
//  5. Port 3 grants a read in cycle t; rst_n asserted low in t+1 before the
//     clock edge -> rd_rvalid_o=0 immediately, and still 0 after release.
//     Pointers are back at 0.
//  6. N_PORTS=3 build, constant requests on all ports for 7 cycles -> read
//     grants 0,1,2,0,1,2,0. No grant has more than one bit set (assertion).

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file port arbiter.
package rf_arb_pkg;

  localparam int DEFAULT_N_PORTS = 4;
  localparam int MAX_PORTS       = 32;
  localparam int RF_READ_LATENCY = 1;

  typedef logic [$clog2(DEFAULT_N_PORTS)-1:0] port_idx_t;

  // Callers guarantee at most one bit is set; zero maps to index 0.
  function automatic int unsigned onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rf_1r1w_port_arbiter_if.sv
// Requester-side read/write request bundle; suffixes follow the arbiter's view.
interface rf_1r1w_port_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);

  logic [N_PORTS-1:0]            rd_req_i;
  logic [N_PORTS*ADDR_WIDTH-1:0] rd_addr_i;
  logic [N_PORTS-1:0]            rd_gnt_o;
  logic [N_PORTS-1:0]            rd_rvalid_o;
  logic [DATA_WIDTH-1:0]         rd_rdata_o;
  logic [N_PORTS-1:0]            wr_req_i;
  logic [N_PORTS*ADDR_WIDTH-1:0] wr_addr_i;
  logic [N_PORTS*DATA_WIDTH-1:0] wr_data_i;
  logic [N_PORTS-1:0]            wr_gnt_o;

  modport master (
    output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
    input  rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o
  );

  modport slave (
    input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
    output rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o
  );

endinterface

// File: rtl/rf_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from req and the priority pointer.
module rf_rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  localparam int IDX_W  = $clog2(N_PORTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam int unsigned NP = N_PORTS;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel;
  logic             found;
  int unsigned      cand;

  // Wrap is an explicit subtract so non-power-of-two port counts stay in range.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    ptr_d = ptr_q;
    for (int off = 0; off < N_PORTS; off++) begin
      cand = 32'(ptr_q) + 32'(off);
      if (cand >= NP) cand = cand - NP;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
    if (found) begin
      gnt_o[sel] = 1'b1;
      ptr_d      = (sel == IDX_W'(N_PORTS-1)) ? '0 : sel + 1'b1;
    end
  end

  assign idx_o = IDX_W'(onehot_to_idx(MAX_PORTS'(gnt_o)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_1r1w_port_arbiter.sv
// Shares one 1R1W register file between N_PORTS requesters with independent
// round-robin read and write arbitration and a one-cycle read response path.
module rf_1r1w_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  localparam int IDX_W     = $clog2(N_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rf_1r1w_port_arbiter_if.slave bus,
  output logic                  rf_ren_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  rf_wen_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o
);

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0] rd_id_q, rd_id_d;

  rf_rr_arbiter #(.N_PORTS(N_PORTS)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (bus.rd_req_i),
    .gnt_o (bus.rd_gnt_o),
    .idx_o (rd_idx)
  );

  rf_rr_arbiter #(.N_PORTS(N_PORTS)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (bus.wr_req_i),
    .gnt_o (bus.wr_gnt_o),
    .idx_o (wr_idx)
  );

  assign rf_ren_o = |bus.rd_gnt_o;
  assign rf_wen_o = |bus.wr_gnt_o;

  always_comb begin
    rf_raddr_o = '0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (rf_ren_o) rf_raddr_o = bus.rd_addr_i[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
    if (rf_wen_o) begin
      rf_waddr_o = bus.wr_addr_i[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
      rf_wdata_o = bus.wr_data_i[wr_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Remember who was granted so the registered RF data is steered back next cycle.
  always_comb begin
    rd_pend_d = rf_ren_o;
    rd_id_d   = rf_ren_o ? rd_idx : rd_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  always_comb begin
    bus.rd_rvalid_o = '0;
    if (rd_pend_q) bus.rd_rvalid_o[rd_id_q] = 1'b1;
  end

  assign bus.rd_rdata_o = rf_rdata_i;

endmodule

// File: tb/tb_rf_1r1w_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural arbitration/RF model; a 3-port build checks odd-count wrap.
module tb_rf_1r1w_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 5;
  localparam int DW = 64;

  logic clk;
  logic rst_n;

  rf_1r1w_port_arbiter_if #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus4 ();
  rf_1r1w_port_arbiter_if #(.N_PORTS(3),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  logic          rfRen, rfWen;
  logic [AW-1:0] rfRaddr, rfWaddr;
  logic [DW-1:0] rfRdata, rfWdata;

  logic          rf3Ren, rf3Wen;
  logic [AW-1:0] rf3Raddr, rf3Waddr;
  logic [DW-1:0] rf3Wdata;

  rf_1r1w_port_arbiter #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus4.slave),
    .rf_ren_o   (rfRen),
    .rf_raddr_o (rfRaddr),
    .rf_rdata_i (rfRdata),
    .rf_wen_o   (rfWen),
    .rf_waddr_o (rfWaddr),
    .rf_wdata_o (rfWdata)
  );

  rf_1r1w_port_arbiter #(.N_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus3.slave),
    .rf_ren_o   (rf3Ren),
    .rf_raddr_o (rf3Raddr),
    .rf_rdata_i ('0),
    .rf_wen_o   (rf3Wen),
    .rf_waddr_o (rf3Waddr),
    .rf_wdata_o (rf3Wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with registered read; non-blocking update gives read-before-write.
  logic [DW-1:0] rfMem [32];
  logic          preEn;
  logic [AW-1:0] preAddr;
  logic [DW-1:0] preData;

  always @(posedge clk) begin
    if (rfRen) rfRdata <= rfMem[rfRaddr];
    if (preEn)      rfMem[preAddr] <= preData;
    else if (rfWen) rfMem[rfWaddr] <= rfWdata;
  end

  int checks = 0;
  int errors = 0;

  // Behavioural model: pointers as integers, memory as a plain array.
  int          mRdPtr, mWrPtr, mId;
  bit          mPend;
  logic [DW-1:0] mData;
  logic [DW-1:0] mMem [32];

  function automatic int arb(input logic [NP-1:0] req, input int ptr);
    for (int off = 0; off < NP; off++) begin
      int p;
      p = (ptr + off) % NP;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mRdPtr = 0;
    mWrPtr = 0;
    mId    = 0;
    mPend  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [NP-1:0] rdReq, input logic [NP-1:0] wrReq);
    bus4.rd_req_i = rdReq;
    bus4.wr_req_i = wrReq;
  endtask

  // One clock: compare everything at negedge against the model, then advance it.
  task automatic stepCycle(output logic [NP-1:0] sRdGnt, output logic [NP-1:0] sWrGnt,
                           output logic [NP-1:0] sRvalid, output logic [DW-1:0] sRdata);
    int rg, wg;
    logic [NP-1:0] eRd, eWr, eRv;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    @(negedge clk);
    rg  = arb(bus4.rd_req_i, mRdPtr);
    wg  = arb(bus4.wr_req_i, mWrPtr);
    eRd = (rg >= 0) ? (4'b0001 << rg) : 4'b0000;
    eWr = (wg >= 0) ? (4'b0001 << wg) : 4'b0000;
    eRv = mPend ? (4'b0001 << mId) : 4'b0000;
    ra  = (rg >= 0) ? bus4.rd_addr_i[rg*AW +: AW] : '0;
    wa  = (wg >= 0) ? bus4.wr_addr_i[wg*AW +: AW] : '0;
    wd  = (wg >= 0) ? bus4.wr_data_i[wg*DW +: DW] : '0;
    checkOutput("rd_gnt", 64'(bus4.rd_gnt_o), 64'(eRd));
    checkOutput("wr_gnt", 64'(bus4.wr_gnt_o), 64'(eWr));
    checkOutput("rf_ren", 64'(rfRen), 64'(rg >= 0));
    checkOutput("rf_raddr", 64'(rfRaddr), 64'(ra));
    checkOutput("rf_wen", 64'(rfWen), 64'(wg >= 0));
    checkOutput("rf_waddr", 64'(rfWaddr), 64'(wa));
    checkOutput("rf_wdata", rfWdata, wd);
    checkOutput("rvalid", 64'(bus4.rd_rvalid_o), 64'(eRv));
    if (mPend) checkOutput("rdata", bus4.rd_rdata_o, mData);
    sRdGnt  = bus4.rd_gnt_o;
    sWrGnt  = bus4.wr_gnt_o;
    sRvalid = bus4.rd_rvalid_o;
    sRdata  = bus4.rd_rdata_o;
    @(posedge clk);
    mPend = (rg >= 0);
    if (rg >= 0) begin
      mId    = rg;
      mData  = mMem[ra];
      mRdPtr = (rg + 1) % NP;
    end
    if (wg >= 0) begin
      mMem[wa] = wd;
      mWrPtr   = (wg + 1) % NP;
    end
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    modelReset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [NP-1:0] gR, gW, rv;
  logic [DW-1:0] rd;

  initial begin
    rst_n = 1'b0;
    preEn = 1'b0;
    preAddr = '0;
    preData = '0;
    bus4.rd_req_i = '0;  bus4.rd_addr_i = '0;
    bus4.wr_req_i = '0;  bus4.wr_addr_i = '0;  bus4.wr_data_i = '0;
    bus3.rd_req_i = '0;  bus3.rd_addr_i = '0;
    bus3.wr_req_i = '0;  bus3.wr_addr_i = '0;  bus3.wr_data_i = '0;
    modelReset();

    // Preload the whole RF (and the model) while reset is held.
    for (int i = 0; i < 32; i++) begin
      preEn   = 1'b1;
      preAddr = 5'(i);
      preData = (i == 3) ? 64'hA5 : (i == 7) ? 64'h0BAD : {$urandom, $urandom};
      mMem[i] = preData;
      @(posedge clk);
      #1;
    end
    preEn = 1'b0;

    @(negedge clk);
    checkOutput("reset_rvalid", 64'(bus4.rd_rvalid_o), 64'h0);
    checkOutput("reset_rd_gnt", 64'(bus4.rd_gnt_o), 64'h0);
    checkOutput("reset_rf_ren", 64'(rfRen), 64'h0);
    checkOutput("reset_rf_raddr", 64'(rfRaddr), 64'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] scenario 1: all ports read continuously");
    for (int p = 0; p < NP; p++) bus4.rd_addr_i[p*AW +: AW] = 5'(p + 10);
    applyStimulus(4'b1111, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      stepCycle(gR, gW, rv, rd);
      checkOutput("t1_gnt_order", 64'(gR), 64'(4'b0001 << (i % 4)));
      if (i > 0) checkOutput("t1_rvalid", 64'(rv), 64'(4'b0001 << ((i - 1) % 4)));
    end
    applyStimulus(4'b0000, 4'b0000);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t1_last_rvalid", 64'(rv), 64'h8);

    $display("[TB] scenario 2: port 2 reads preloaded address 3");
    bus4.rd_addr_i[2*AW +: AW] = 5'd3;
    applyStimulus(4'b0100, 4'b0000);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t2_gnt", 64'(gR), 64'h4);
    applyStimulus(4'b0000, 4'b0000);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t2_rvalid", 64'(rv), 64'h4);
    checkOutput("t2_rdata", rd, 64'hA5);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t2_rvalid_drop", 64'(rv), 64'h0);

    $display("[TB] scenario 3: same-address read and write");
    bus4.rd_addr_i[0*AW +: AW] = 5'd7;
    bus4.wr_addr_i[1*AW +: AW] = 5'd7;
    bus4.wr_data_i[1*DW +: DW] = 64'h1234;
    applyStimulus(4'b0001, 4'b0010);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t3_rd_gnt", 64'(gR), 64'h1);
    checkOutput("t3_wr_gnt", 64'(gW), 64'h2);
    applyStimulus(4'b0001, 4'b0000);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t3_old_data", rd, 64'h0BAD);
    applyStimulus(4'b0000, 4'b0000);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t3_new_data", rd, 64'h1234);

    $display("[TB] scenario 4: independent read/write arbitration");
    resetDut();
    applyStimulus(4'b0101, 4'b1010);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t4_rd_gnt0", 64'(gR), 64'h1);
    checkOutput("t4_wr_gnt0", 64'(gW), 64'h2);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t4_rd_gnt1", 64'(gR), 64'h4);
    checkOutput("t4_wr_gnt1", 64'(gW), 64'h8);

    $display("[TB] scenario 5: reset while a read is pending");
    applyStimulus(4'b1000, 4'b0000);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t5_gnt", 64'(gR), 64'h8);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("t5_rvalid_before", 64'(bus4.rd_rvalid_o), 64'h8);
    #1 rst_n = 1'b0;
    modelReset();
    #1 checkOutput("t5_rvalid_async", 64'(bus4.rd_rvalid_o), 64'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b1111);
    stepCycle(gR, gW, rv, rd);
    checkOutput("t5_rvalid_after", 64'(rv), 64'h0);
    checkOutput("t5_rd_ptr0", 64'(gR), 64'h1);
    checkOutput("t5_wr_ptr0", 64'(gW), 64'h1);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (gR[p] || !bus4.rd_req_i[p]) begin
          bus4.rd_req_i[p] = 1'($urandom_range(0, 1));
          bus4.rd_addr_i[p*AW +: AW] = 5'($urandom_range(0, 31));
        end
        if (gW[p] || !bus4.wr_req_i[p]) begin
          bus4.wr_req_i[p] = 1'($urandom_range(0, 1));
          bus4.wr_addr_i[p*AW +: AW] = 5'($urandom_range(0, 31));
          bus4.wr_data_i[p*DW +: DW] = {$urandom, $urandom};
        end
      end
      stepCycle(gR, gW, rv, rd);
    end
    applyStimulus(4'b0000, 4'b0000);
    stepCycle(gR, gW, rv, rd);

    $display("[TB] scenario 6: three-port build wrap");
    bus3.rd_req_i = 3'b111;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput("t6_gnt3", 64'(bus3.rd_gnt_o), 64'(3'b001 << (i % 3)));
      checkOutput("t6_onehot", 64'($onehot0(bus3.rd_gnt_o)), 64'h1);
      @(posedge clk);
      #1;
    end
    bus3.rd_req_i = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
